// File: rtl/edge_pkg.sv
// Shared types for the Sobel window path: pixel width, window state and 3x3 window layout.
package edge_pkg;

    localparam int DEF_PIX_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } win_state_t;

    // p00 lands in the MSBs; p22 is the newest pixel.
    typedef struct packed {
        logic [DEF_PIX_W-1:0] p00;
        logic [DEF_PIX_W-1:0] p01;
        logic [DEF_PIX_W-1:0] p02;
        logic [DEF_PIX_W-1:0] p10;
        logic [DEF_PIX_W-1:0] p11;
        logic [DEF_PIX_W-1:0] p12;
        logic [DEF_PIX_W-1:0] p20;
        logic [DEF_PIX_W-1:0] p21;
        logic [DEF_PIX_W-1:0] p22;
    } window_t;

endpackage

// File: rtl/sobel_line_mem.sv
// One image line of pixel storage: combinational read, synchronous write at the same index.
module sobel_line_mem #(
    parameter int PIX_W = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [PIX_W-1:0]         wdata,
    output logic [PIX_W-1:0]         rdata
);

    logic [PIX_W-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    // Contents are deliberately not reset; stale data never reaches an emitted window.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/sobel_window_buffer.sv
// Streaming 3x3 window generator feeding the Sobel gradient calculator.
// Optional frame_done output enabled by defining SOBEL_WINDOW_FRAME_DONE_EN.
//
// state  | meaning
// IDLE   | frame not started, waiting for first pixel
// FILL   | pixels arriving, no window emitted yet
// STREAM | windows being emitted
// DONE   | last pixel of frame taken; final window may still drain
module sobel_window_buffer
    import edge_pkg::*;
#(
    parameter int PIX_W = DEF_PIX_W,
    parameter int IMG_W = 16,
    parameter int IMG_H = 16
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     enable_calc,
    input  logic                     buffer_clear,
    input  logic                     pix_valid,
    input  logic [PIX_W-1:0]         pix_data,
    output logic                     pix_ready,
    output logic                     win_valid,
    input  logic                     win_ready,
    output logic [9*PIX_W-1:0]       win_data,
    output logic [$clog2(IMG_W)-1:0] win_x,
`ifdef SOBEL_WINDOW_FRAME_DONE_EN
    output logic [$clog2(IMG_H)-1:0] win_y,
    output logic                     frame_done
`else
    output logic [$clog2(IMG_H)-1:0] win_y
`endif
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    win_state_t state_q, state_d;
    logic [XW-1:0] col_q;
    logic [YW-1:0] row_q;
    logic [8:0][PIX_W-1:0] win_q;
    logic [PIX_W-1:0] line0_rd, line1_rd;
    logic accept, emit, col_last, row_last, frame_last;

    assign col_last   = (col_q == X_LAST);
    assign row_last   = (row_q == Y_LAST);
    assign frame_last = col_last && row_last;

    // Reset and clear both block acceptance so the dropped pixel never touches the line stores.
    assign pix_ready = n_rst && !buffer_clear && enable_calc && (state_q != DONE)
                       && (!win_valid || win_ready);
    assign accept    = pix_valid && pix_ready;
    assign emit      = accept && (col_q >= XW'(2)) && (row_q >= YW'(2));

    sobel_line_mem #(.PIX_W(PIX_W), .DEPTH(IMG_W)) u_line0 (
        .clk   (clk),
        .we    (accept),
        .addr  (col_q),
        .wdata (pix_data),
        .rdata (line0_rd)
    );

    sobel_line_mem #(.PIX_W(PIX_W), .DEPTH(IMG_W)) u_line1 (
        .clk   (clk),
        .we    (accept),
        .addr  (col_q),
        .wdata (line0_rd),
        .rdata (line1_rd)
    );

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (buffer_clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (accept) state_d = FILL;
                FILL: begin
                    if (accept && frame_last) state_d = DONE;
                    else if (emit)            state_d = STREAM;
                end
                STREAM:  if (accept && frame_last) state_d = DONE;
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            col_q     <= '0;
            row_q     <= '0;
            win_valid <= 1'b0;
            win_q     <= '0;
            win_x     <= '0;
            win_y     <= '0;
        end else if (buffer_clear) begin
            col_q     <= '0;
            row_q     <= '0;
            win_valid <= 1'b0;
        end else begin
            if (accept) begin
                if (col_last) begin
                    col_q <= '0;
                    row_q <= row_last ? '0 : row_q + YW'(1);
                end else begin
                    col_q <= col_q + XW'(1);
                end
                // Each window row shifts left; the new right column is {line1, line0, pixel}.
                win_q[8] <= win_q[7];
                win_q[7] <= win_q[6];
                win_q[6] <= line1_rd;
                win_q[5] <= win_q[4];
                win_q[4] <= win_q[3];
                win_q[3] <= line0_rd;
                win_q[2] <= win_q[1];
                win_q[1] <= win_q[0];
                win_q[0] <= pix_data;
            end
            if (emit) begin
                win_valid <= 1'b1;
                win_x     <= col_q - XW'(1);
                win_y     <= row_q - YW'(1);
            end else if (win_ready) begin
                win_valid <= 1'b0;
            end
        end
    end

    assign win_data = win_q;

`ifdef SOBEL_WINDOW_FRAME_DONE_EN
    assign frame_done = win_valid && win_ready
                        && (win_x == X_LAST - XW'(1)) && (win_y == Y_LAST - YW'(1));
`endif

endmodule

// File: tb/tb_sobel_window_buffer.sv
// Scoreboard bench for sobel_window_buffer: expected windows queued at stimulus, popped by a monitor.
module tb_sobel_window_buffer;
    import edge_pkg::*;

    localparam int W = 16;
    localparam int H = 16;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic enable_calc = 1'b0;
    logic buffer_clear = 1'b0;
    logic pix_valid = 1'b0;
    logic [7:0] pix_data = 8'h00;
    logic win_ready = 1'b1;
    logic pix_ready, win_valid;
    logic [71:0] win_data;
    logic [3:0] win_x, win_y;
`ifdef SOBEL_WINDOW_FRAME_DONE_EN
    logic frame_done;
    int n_fd = 0;
`endif

    typedef struct packed {
        logic [3:0]  x;
        logic [3:0]  y;
        logic [71:0] d;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int errors = 0;
    int checks = 0;
    int n_hs = 0;
    logic [71:0] first_d, last_d;
    logic [3:0] first_x, first_y, last_x, last_y;

    sobel_window_buffer #(.PIX_W(8), .IMG_W(W), .IMG_H(H)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .enable_calc  (enable_calc),
        .buffer_clear (buffer_clear),
        .pix_valid    (pix_valid),
        .pix_data     (pix_data),
        .pix_ready    (pix_ready),
        .win_valid    (win_valid),
        .win_ready    (win_ready),
        .win_data     (win_data),
        .win_x        (win_x),
`ifdef SOBEL_WINDOW_FRAME_DONE_EN
        .win_y        (win_y),
        .frame_done   (frame_done)
`else
        .win_y        (win_y)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] pv(input int x, input int y, input int seed);
        return 8'((16 * y + x + seed) & 255);
    endfunction

    function automatic logic [71:0] ew(input int x, input int y, input int seed);
        window_t w;
        w.p00 = pv(x - 2, y - 2, seed);
        w.p01 = pv(x - 1, y - 2, seed);
        w.p02 = pv(x,     y - 2, seed);
        w.p10 = pv(x - 2, y - 1, seed);
        w.p11 = pv(x - 1, y - 1, seed);
        w.p12 = pv(x,     y - 1, seed);
        w.p20 = pv(x - 2, y,     seed);
        w.p21 = pv(x - 1, y,     seed);
        w.p22 = pv(x,     y,     seed);
        return w;
    endfunction

    // Monitor: every handshake pops one expected window.
    always @(negedge clk) begin
        if (n_rst && win_valid && win_ready) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_window: got x=%0d y=%0d data=%h, none expected", win_x, win_y, win_data);
            end else begin
                mon_e = q.pop_front();
                if (win_x !== mon_e.x || win_y !== mon_e.y || win_data !== mon_e.d) begin
                    errors++;
                    $display("FAIL window: got x=%0d y=%0d data=%h, expected x=%0d y=%0d data=%h",
                             win_x, win_y, win_data, mon_e.x, mon_e.y, mon_e.d);
                end
`ifdef SOBEL_WINDOW_FRAME_DONE_EN
                checks++;
                if (frame_done !== (mon_e.x == 4'd14 && mon_e.y == 4'd14)) begin
                    errors++;
                    $display("FAIL frame_done_at_hs: got %b at x=%0d y=%0d", frame_done, mon_e.x, mon_e.y);
                end
                if (frame_done) n_fd++;
`endif
            end
            if (n_hs == 0) begin
                first_d = win_data; first_x = win_x; first_y = win_y;
            end
            last_d = win_data; last_x = win_x; last_y = win_y;
            n_hs++;
        end
`ifdef SOBEL_WINDOW_FRAME_DONE_EN
        if (frame_done && !(win_valid && win_ready)) begin
            checks++;
            errors++;
            $display("FAIL frame_done_stray: got 1 without handshake, expected 0");
        end
`endif
    end

    task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic send_pix(input int x, input int y, input int seed);
        int t = 0;
        pix_valid = 1'b1;
        pix_data  = pv(x, y, seed);
        @(negedge clk);
        while (!pix_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (!pix_ready) begin
            errors++;
            $display("FAIL accept_timeout: pix_ready=0 at x=%0d y=%0d, expected 1", x, y);
        end else if (x >= 2 && y >= 2) begin
            q.push_back('{x: 4'(x - 1), y: 4'(y - 1), d: ew(x, y, seed)});
        end
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
    endtask

    task automatic run_frame(input int seed, input int npix, input bit en_drop);
        int k = 0;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                if (k < npix) begin
                    if (en_drop && x == 7 && y == 5) begin
                        enable_calc = 1'b0;
                        pix_valid   = 1'b1;
                        pix_data    = pv(x, y, seed);
                        repeat (10) begin
                            @(negedge clk);
                            check("en_low_pix_ready", {71'd0, pix_ready}, 72'd0);
                        end
                        @(posedge clk);
                        #1;
                        enable_calc = 1'b1;
                    end
                    send_pix(x, y, seed);
                    k++;
                end
            end
        end
    endtask

    task automatic backpressure();
        int t = 0;
        logic [71:0] held;
        while (n_hs < 20 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        checks++;
        if (n_hs < 20) begin
            errors++;
            $display("FAIL bp_wait: handshakes=%0d expected 20", n_hs);
        end else begin
            #1;
            win_ready = 1'b0;
            held = 72'd0;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                check("bp_win_valid", {71'd0, win_valid}, 72'd1);
                check("bp_pix_ready", {71'd0, pix_ready}, 72'd0);
                if (i == 0) held = win_data;
                else check("bp_data_stable", win_data, held);
            end
            @(posedge clk);
            #1;
            win_ready = 1'b1;
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((q.size() != 0 || win_valid) && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("drain_queue_empty", 72'(q.size()), 72'd0);
    endtask

    task automatic pulse_clear(input bit with_pixel);
        @(posedge clk);
        #1;
        buffer_clear = 1'b1;
        pix_valid    = with_pixel;
        pix_data     = 8'hAA;
        @(negedge clk);
        check("clear_pix_ready", {71'd0, pix_ready}, 72'd0);
        @(posedge clk);
        #1;
        buffer_clear = 1'b0;
        pix_valid    = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_win_valid", {71'd0, win_valid}, 72'd0);
        check("rst_win_x", {68'd0, win_x}, 72'd0);
        check("rst_win_y", {68'd0, win_y}, 72'd0);
        check("rst_pix_ready", {71'd0, pix_ready}, 72'd0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        enable_calc = 1'b1;
        @(negedge clk);
        check("en_pix_ready", {71'd0, pix_ready}, 72'd1);
        @(posedge clk);
        #1;

        // Frame 1: plain full frame with hand-checked first and last windows.
        n_hs = 0;
        run_frame(0, W * H, 1'b0);
        drain();
        check("f1_count", 72'(n_hs), 72'd196);
        check("f1_first_x", {68'd0, first_x}, 72'd1);
        check("f1_first_y", {68'd0, first_y}, 72'd1);
        check("f1_first_data", first_d, 72'h00_01_02_10_11_12_20_21_22);
        check("f1_last_x", {68'd0, last_x}, 72'd14);
        check("f1_last_y", {68'd0, last_y}, 72'd14);
        check("f1_last_p22", {64'd0, last_d[7:0]}, 72'hFF);
        @(negedge clk);
        check("f1_done_pix_ready", {71'd0, pix_ready}, 72'd0);

        // Frame 2: 40 pixels then a clear carrying a pixel that must be dropped.
        pulse_clear(1'b0);
        n_hs = 0;
        run_frame(5, 40, 1'b0);
        repeat (3) @(negedge clk);
        check("f2_partial_count", 72'(n_hs), 72'd6);
        check("f2_queue_empty", 72'(q.size()), 72'd0);
        pulse_clear(1'b1);

        // Frame 3: backpressure at window 20 and enable_calc drop at (7,5).
        n_hs = 0;
        fork
            run_frame(9, W * H, 1'b1);
            backpressure();
        join
        drain();
        check("f3_count", 72'(n_hs), 72'd196);
        @(negedge clk);
        check("f3_done_pix_ready", {71'd0, pix_ready}, 72'd0);
`ifdef SOBEL_WINDOW_FRAME_DONE_EN
        check("frame_done_pulses", 72'(n_fd), 72'd2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
